// File: rtl/uart_rx_fifo_if.sv
// Valid/ready output bundle of the UART receiver FIFO.
// master: receiver side, slave: consumer side.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output m_data,
    output m_parity_err,
    output m_frame_err,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_parity_err,
    input  m_frame_err,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority vote, per-byte error flags and output FIFO.
// Optional break detection: define UART_RX_BREAK_DET_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           oversample_tick,
  input  logic           rxd,
  uart_rx_fifo_if.master m,
  output logic           overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic           break_det,
`endif
  output logic           rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST  = IW'(DATA_BITS - 1);
  localparam logic          SLAST = 1'(STOP_BITS - 1);
  localparam logic [PW:0]   DEPTH = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [2:0]           hist_q, hist_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 scnt_q, scnt_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 psmp_q, psmp_d;
  logic                 brk_q, brk_d;
  logic                 break_q, break_d;
  logic                 is_break;
`endif

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, wr_d;
  logic [PW-1:0]        rd_q, rd_d;
  logic [PW:0]          count_q, count_d;
  logic                 overrun_q, overrun_d;

  logic                 vote;
  logic                 ferr_n;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        head;

  assign vote   = (hist_q[0] & hist_q[1]) |
                  (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);
  assign ferr_n = ferr_q | ~vote;
  assign entry  = {ferr_n, perr_q, shreg_q};

`ifdef UART_RX_BREAK_DET_EN
  // Break: all-zero data, missing stop bit and (if present) a low parity sample.
  assign is_break = (shreg_q == '0) && ferr_n &&
                    ((PARITY == 0) || !psmp_q);
`endif

  always_comb begin
    state_d = state_q;
    sync1_d = rxd;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    scnt_d  = scnt_q;
    push    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    psmp_d  = psmp_q;
    brk_d   = brk_q;
    break_d = 1'b0;
`endif
    if (oversample_tick) begin
      hist_d = {hist_q[1:0], sync2_q};
      unique case (state_q)
        S_IDLE: begin
          if (!vote) begin
            state_d = S_START;
            cnt_d   = HALF;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!vote) begin
            state_d = S_DATA;
            cnt_d   = FULL;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
            cnt_d   = FULL;
            if (idx_q == LAST) begin
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              scnt_d  = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            perr_d  = (((^shreg_q) ^ vote) != (PARITY == 2));
`ifdef UART_RX_BREAK_DET_EN
            psmp_d  = vote;
`endif
            cnt_d   = FULL;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            ferr_d = ferr_n;
            if (scnt_q != SLAST) begin
              scnt_d = scnt_q + 1'b1;
              cnt_d  = FULL;
            end else begin
              state_d = S_WAIT;
              cnt_d   = HALF;
`ifdef UART_RX_BREAK_DET_EN
              if (is_break) begin
                brk_d   = 1'b1;
                break_d = 1'b1;
              end else begin
                push = 1'b1;
              end
`else
              push = 1'b1;
`endif
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          end else if (!brk_q || vote) begin
            state_d = S_IDLE;
            brk_d   = 1'b0;
          end
`else
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign full    = (count_q == DEPTH);
  assign pop     = (count_q != '0) & m.m_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = push & (~full | pop);

  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    overrun_d = push & full & ~pop;
    if (push_ok) begin
      mem_d[wr_q] = entry;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      hist_q    <= 3'b111;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      scnt_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      psmp_q    <= 1'b0;
      brk_q     <= 1'b0;
      break_q   <= 1'b0;
`endif
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      scnt_q    <= scnt_d;
`ifdef UART_RX_BREAK_DET_EN
      psmp_q    <= psmp_d;
      brk_q     <= brk_d;
      break_q   <= break_d;
`endif
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign head           = mem_q[rd_q];
  assign m.m_data       = head[DATA_BITS-1:0];
  assign m.m_parity_err = head[DATA_BITS];
  assign m.m_frame_err  = head[DATA_BITS+1];
  assign m.m_valid      = (count_q != '0);
  assign overrun        = overrun_q;
  assign rx_busy        = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign break_det      = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: default build (A) and even-parity / 2-stop build (B).
// Expected bytes come from a queue model fed by the frames the bench sends.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic line = 1'b1;
  logic sel_b = 1'b0;
  logic rxd_a, rxd_b;
  logic ovr_a, ovr_b, busy_a, busy_b;
`ifdef UART_RX_BREAK_DET_EN
  logic brk_a, brk_b;
`endif

  int div = 0;
  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int exp_ovr = 0;
  int rises = 0;
  int rise_bad = 0;
  int brk_cnt = 0;
  logic pt, pv;
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [7:0] rd;
  logic [7:0] v5a;

  uart_rx_fifo_if #(.DATA_BITS(8)) ifa ();
  uart_rx_fifo_if #(.DATA_BITS(8)) ifb ();

  assign rxd_a = sel_b ? 1'b1 : line;
  assign rxd_b = sel_b ? line : 1'b1;

  uart_rx_fifo u_a (
    .clk(clk),
    .reset(reset),
    .oversample_tick(tick),
    .rxd(rxd_a),
    .m(ifa),
    .overrun(ovr_a),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_a),
`endif
    .rx_busy(busy_a)
  );

  uart_rx_fifo #(.PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk),
    .reset(reset),
    .oversample_tick(tick),
    .rxd(rxd_b),
    .m(ifb),
    .overrun(ovr_b),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_b),
`endif
    .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div  <= (div + 1) % 4;
    tick <= (div == 3);
  end

  always @(posedge clk) begin
    pt = tick;
    pv = ifa.m_valid;
    #1;
    if (!pv && ifa.m_valid) begin
      rises++;
      if (!pt) rise_bad++;
    end
    if (ovr_a) ovr_cnt++;
`ifdef UART_RX_BREAK_DET_EN
    if (brk_a) brk_cnt++;
`endif
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    do @(posedge clk); while (tick !== 1'b1);
  endtask

  task automatic send_bit(input logic v, input bit g);
    for (int t = 0; t < 16; t++) begin
      line = (g && t == 8) ? ~v : v;
      next_tick();
      #1;
    end
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par,
                            input logic pbit, input int nstop,
                            input logic s2, input int gbit);
    send_bit(1'b0, gbit == 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], gbit == i + 1);
    if (par) send_bit(pbit, 1'b0);
    send_bit(1'b1, 1'b0);
    if (nstop == 2) send_bit(s2, 1'b0);
    line = 1'b1;
  endtask

  task automatic model_push(input bit b, input logic [7:0] d,
                            input logic perr, input logic ferr);
    if (b) begin
      qb.push_back({ferr, perr, d});
    end else if (qa.size() == 4) begin
      exp_ovr++;
    end else begin
      qa.push_back({ferr, perr, d});
    end
  endtask

  task automatic send_b(input logic [7:0] d, input logic pbit,
                        input logic s2);
    send_frame(d, 1'b1, pbit, 2, s2, -1);
    model_push(1'b1, d, ($countones({d, pbit}) % 2) != 0, !s2);
  endtask

  task automatic pop_now(input bit b, input string tag);
    logic [9:0] got, exp;
    logic v;
    v   = b ? ifb.m_valid : ifa.m_valid;
    got = b ? {ifb.m_frame_err, ifb.m_parity_err, ifb.m_data}
            : {ifa.m_frame_err, ifa.m_parity_err, ifa.m_data};
    exp = 10'h3ff;
    if (b && qb.size() > 0) exp = qb.pop_front();
    if (!b && qa.size() > 0) exp = qa.pop_front();
    chk({tag, "_valid"}, 32'(v), 32'(1));
    chk({tag, "_entry"}, 32'(got), 32'(exp));
    if (b) ifb.m_ready = 1'b1;
    else ifa.m_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.m_ready = 1'b0;
    ifb.m_ready = 1'b0;
  endtask

  task automatic pop_check(input bit b, input string tag);
    int n;
    n = 0;
    while (!(b ? ifb.m_valid : ifa.m_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    pop_now(b, tag);
  endtask

  initial begin
    ifa.m_ready = 1'b0;
    ifb.m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ifa.m_valid), 32'(0));
    chk("rst_overrun", 32'(ovr_a), 32'(0));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_data", 32'(ifa.m_data), 32'(0));
    chk("rst_flags", 32'({ifa.m_frame_err, ifa.m_parity_err}), 32'(0));
    chk("rst_valid_b", 32'(ifb.m_valid), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    idle_bits(2);

    // Two frames, one idle bit apart
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, -1);
    model_push(1'b0, 8'hA5, 1'b0, 1'b0);
    pop_check(1'b0, "t1_a5");
    idle_bits(1);
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b1, -1);
    model_push(1'b0, 8'h3C, 1'b0, 1'b0);
    pop_check(1'b0, "t1_3c");
    chk("t1_rises", 32'(rises), 32'(2));
    chk("t1_rise_on_tick", 32'(rise_bad), 32'(0));

    // Random bytes with random idle gaps
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      idle_bits(int'($urandom_range(0, 2)));
      send_frame(rd, 1'b0, 1'b0, 1, 1'b1, -1);
      model_push(1'b0, rd, 1'b0, 1'b0);
      pop_check(1'b0, "rnd");
    end

    // Overflow with consumer stalled
    idle_bits(1);
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1, 1'b1, -1);
      model_push(1'b0, 8'(i), 1'b0, 1'b0);
      idle_bits(1);
    end
    chk("t4_overrun_once", 32'(ovr_cnt), 32'(exp_ovr));
    chk("t4_exp_one", 32'(ovr_cnt), 32'(1));
    for (int i = 0; i < 4; i++) pop_check(1'b0, "t4_drain");
    chk("t4_empty", 32'(ifa.m_valid), 32'(0));

    // Fifth push into a full FIFO meets a pop in the same cycle
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1, 1'b1, -1);
      model_push(1'b0, 8'(i), 1'b0, 1'b0);
      idle_bits(1);
    end
    v5a = 8'h05;
    next_tick();
    #1;
    fork
      send_frame(v5a, 1'b0, 1'b0, 1, 1'b1, -1);
      begin
        repeat (154) next_tick();
        do begin
          @(negedge clk);
          #1;
        end while (tick !== 1'b1);
        pop_now(1'b0, "t4_pop_full");
      end
    join
    model_push(1'b0, v5a, 1'b0, 1'b0);
    chk("t4_no_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    for (int i = 0; i < 4; i++) pop_check(1'b0, "t4_drain2");

    // Glitch on idle line is filtered
    idle_bits(1);
    line = 1'b0;
    next_tick();
    #1;
    line = 1'b1;
    repeat (40) next_tick();
    #1;
    chk("t5_glitch_busy", 32'(busy_a), 32'(0));
    chk("t5_glitch_nopush", 32'(ifa.m_valid), 32'(0));
    // Inverted sample near the middle of data bit 4
    send_frame(8'hF0, 1'b0, 1'b0, 1, 1'b1, 5);
    model_push(1'b0, 8'hF0, 1'b0, 1'b0);
    pop_check(1'b0, "t5_f0");

    // Reset in the middle of a frame with two entries queued
    idle_bits(1);
    send_frame(8'h11, 1'b0, 1'b0, 1, 1'b1, -1);
    idle_bits(1);
    send_frame(8'h22, 1'b0, 1'b0, 1, 1'b1, -1);
    idle_bits(1);
    chk("t6_queued", 32'(ifa.m_valid), 32'(1));
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    line = 1'b1;
    repeat (8) next_tick();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid_cleared", 32'(ifa.m_valid), 32'(0));
    chk("t6_busy_cleared", 32'(busy_a), 32'(0));
    chk("t6_data_cleared", 32'(ifa.m_data), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    idle_bits(2);
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1, -1);
    model_push(1'b0, 8'h81, 1'b0, 1'b0);
    pop_check(1'b0, "t6_81");

    // Twelve bit times of low line
    idle_bits(1);
    for (int i = 0; i < 12; i++) send_bit(1'b0, 1'b0);
    line = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
    idle_bits(3);
    chk("brk_pulse", 32'(brk_cnt), 32'(1));
    chk("brk_nopush", 32'(ifa.m_valid), 32'(0));
    chk("brk_idle", 32'(busy_a), 32'(0));
`else
    model_push(1'b0, 8'h00, 1'b0, 1'b1);
    pop_check(1'b0, "brk_as_data");
    idle_bits(14);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    qa.delete();
`endif

    // Even parity and two stop bits on the second instance
    sel_b = 1'b1;
    idle_bits(2);
    send_b(8'h07, 1'b0, 1'b1);
    idle_bits(1);
    pop_check(1'b1, "t2_perr");
    send_b(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    pop_check(1'b1, "t2_pok");
    send_b(8'h55, 1'b0, 1'b0);
    idle_bits(1);
    pop_check(1'b1, "t3_ferr");
    rd = 8'($urandom);
    send_b(rd, 1'($countones(rd) % 2), 1'b1);
    idle_bits(1);
    pop_check(1'b1, "t3_rnd_ok");
    chk("b_empty", 32'(ifb.m_valid), 32'(0));
    chk("b_no_overrun", 32'(ovr_b), 32'(0));

    chk("all_rises_on_tick", 32'(rise_bad), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
